// File: rtl/aes_ctrl_pkg.sv
// Shared types and sizing helpers for the AES round sequencer.
// Used by aes_step_counter and aes_round_sequencer.
package aes_ctrl_pkg;

  localparam int CNT_W = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KRST,
    S_KEXP,
    S_LOAD,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  function automatic int nr(input int nk);
    return nk + 6;
  endfunction

  function automatic int ke_words(input int nk);
    return 4 * (nk + 7);
  endfunction

endpackage

// File: rtl/aes_step_counter.sv
// Loadable down counter with zero flag.
// Shared by the key-expansion and round phases.
module aes_step_counter
  import aes_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/aes_round_sequencer.sv
// Control FSM for the iterative AES engine (key expansion, rounds, output).
// Optional key reuse across blocks: define AES_KEY_CACHE_EN.
module aes_round_sequencer
  import aes_ctrl_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       key_new,
  output logic       ke_reset,
  output logic       ke_enable,
  output logic       ld_state,
  output logic       rnd_en,
  output logic       last_round,
  output logic [3:0] round_idx,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam int NR = nr(NK);
  localparam logic [CNT_W-1:0] KE_LAST = CNT_W'(ke_words(NK) - 1);
  localparam logic [CNT_W-1:0] RND_LAST = CNT_W'(NR - 2);

  state_t           state_q;
  state_t           state_d;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             hit;

`ifdef AES_KEY_CACHE_EN
  logic key_cached;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_cached <= 1'b0;
    end else if (state_q == S_KEXP && cnt_zero) begin
      key_cached <= 1'b1;
    end
  end

  assign hit = key_cached & ~key_new;
`else
  logic unused_key_new;
  assign unused_key_new = key_new;
  assign hit = 1'b0;
`endif

  aes_step_counter u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = hit ? S_LOAD : S_KRST;
        end
      end
      S_KRST: begin
        cnt_load = 1'b1;
        cnt_val  = KE_LAST;
        state_d  = S_KEXP;
      end
      S_KEXP: begin
        if (cnt_zero) begin
          state_d = S_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_LOAD: begin
        cnt_load = 1'b1;
        cnt_val  = RND_LAST;
        state_d  = S_ROUND;
      end
      S_ROUND: begin
        if (cnt_zero) begin
          state_d = S_FINAL;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_FINAL: state_d = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Index tracks the state being entered so it is valid with the strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      round_idx <= '0;
    end else if (state_d == S_LOAD) begin
      round_idx <= '0;
    end else if (state_d == S_ROUND || state_d == S_FINAL) begin
      round_idx <= round_idx + 4'd1;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign ke_reset   = (state_q == S_KRST);
  assign ke_enable  = (state_q == S_KEXP);
  assign ld_state   = (state_q == S_LOAD);
  assign rnd_en     = (state_q == S_ROUND) || (state_q == S_FINAL);
  assign last_round = (state_q == S_FINAL);
  assign out_valid  = (state_q == S_DONE);

endmodule
